axil_master_bridge: RTL and testbench

- Converts the CPU's native valid/ready memory bus into an AXI4-Lite initiator.
- Drives the memory controller's AXI4-Lite device port (ROM, scratchpad, UART).
- One outstanding transaction at a time; reads and writes never overlap.
- A per-transaction timeout returns an error instead of hanging the CPU.

---
 rtl/axil_pkg.sv | 33 +++
 rtl/axil_timeout_timer.sv | 32 +++
 rtl/axil_master_bridge.sv | 197 +++++++++++++++++++
 tb/tb_axil_master_bridge.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared encodings and constants for the AXI4-Lite master bridge
package axil_pkg;

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_RD_ADDR = 4'd1;
   localparam logic [3:0] ST_RD_DATA = 4'd2;
   localparam logic [3:0] ST_WR      = 4'd3;
   localparam logic [3:0] ST_WR_RESP = 4'd4;
   localparam logic [3:0] ST_DONE    = 4'd5;

   typedef enum logic [3:0] {
      S_IDLE    = ST_IDLE,
      S_RD_ADDR = ST_RD_ADDR,
      S_RD_DATA = ST_RD_DATA,
      S_WR      = ST_WR,
      S_WR_RESP = ST_WR_RESP,
      S_DONE    = ST_DONE
   } axil_state_t;

   localparam logic [2:0]  AXPROT_DATA   = 3'b000;
   localparam logic [2:0]  AXPROT_INSTR  = 3'b100;
   localparam logic [31:0] DEF_ERR_RDATA = 32'hdeadbeef;

   // Top address nibble selects the device behind the memory controller.
   localparam logic [3:0] REGION_ROM  = 4'h0;
   localparam logic [3:0] REGION_RAM  = 4'h1;
   localparam logic [3:0] REGION_UART = 4'h2;

   function automatic logic [2:0] prot_of(input logic instr);
      return instr ? AXPROT_INSTR : AXPROT_DATA;
   endfunction

endpackage

// File: rtl/axil_timeout_timer.sv
// rtl/axil_timeout_timer.sv - saturating per-transaction timeout counter
module axil_timeout_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic CLK,
   input  logic RSTb,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int         W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
   localparam logic [W-1:0] LAST  = (TIMEOUT_CYCLES > 0) ? W'(TIMEOUT_CYCLES - 1) : '0;
   localparam bit         ARMED = (TIMEOUT_CYCLES > 0);

   logic [W-1:0] count;

   // Count active cycles since accept; hold at the limit instead of wrapping.
   always_ff @(posedge CLK) begin
      if (!RSTb || clear) begin
         count <= '0;
      end else if (enable && count != LIMIT) begin
         count <= count + 1'b1;
      end
   end

   // Fires on the edge where the count would reach the limit, so the abort
   // and the limit land together.
   assign expire = ARMED && enable && (count >= LAST);

endmodule

// File: rtl/axil_master_bridge.sv
// rtl/axil_master_bridge.sv - CPU valid/ready bus to AXI4-Lite initiator with timeout
module axil_master_bridge
   import axil_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA
) (
   input  logic        CLK,
   input  logic        RSTb,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        bus_err,
   output logic        m_axi_awvalid,
   input  logic        m_axi_awready,
   output logic [31:0] m_axi_awaddr,
   output logic [2:0]  m_axi_awprot,
   output logic        m_axi_wvalid,
   input  logic        m_axi_wready,
   output logic [31:0] m_axi_wdata,
   output logic [3:0]  m_axi_wstrb,
   input  logic        m_axi_bvalid,
   output logic        m_axi_bready,
   output logic        m_axi_arvalid,
   input  logic        m_axi_arready,
   output logic [31:0] m_axi_araddr,
   output logic [2:0]  m_axi_arprot,
   input  logic        m_axi_rvalid,
   output logic        m_axi_rready,
   input  logic [31:0] m_axi_rdata
);

   axil_state_t state, nxt_state;
   logic        aw_done, w_done, nxt_aw_done, nxt_w_done;
   logic        nxt_awvalid, nxt_wvalid, nxt_bready, nxt_arvalid, nxt_rready;
   logic        nxt_mem_ready, nxt_bus_err;
   logic [31:0] nxt_mem_rdata, nxt_awaddr, nxt_araddr, nxt_wdata;
   logic [3:0]  nxt_wstrb;
   logic [2:0]  nxt_awprot, nxt_arprot;
   logic        accept, finish, expire, active, aw_hs, w_hs;

   assign active = (state == S_RD_ADDR) || (state == S_RD_DATA) ||
                   (state == S_WR) || (state == S_WR_RESP);
   assign aw_hs  = m_axi_awvalid && m_axi_awready;
   assign w_hs   = m_axi_wvalid && m_axi_wready;

   axil_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .CLK    (CLK),
      .RSTb   (RSTb),
      .clear  (accept),
      .enable (active),
      .expire (expire)
   );

   // Next-state and next-output decode; completion takes priority over timeout.
   always_comb begin
      nxt_state     = state;
      nxt_aw_done   = aw_done;
      nxt_w_done    = w_done;
      nxt_awvalid   = m_axi_awvalid;
      nxt_wvalid    = m_axi_wvalid;
      nxt_bready    = m_axi_bready;
      nxt_arvalid   = m_axi_arvalid;
      nxt_rready    = m_axi_rready;
      nxt_mem_ready = mem_ready;
      nxt_bus_err   = bus_err;
      nxt_mem_rdata = mem_rdata;
      nxt_awaddr    = m_axi_awaddr;
      nxt_araddr    = m_axi_araddr;
      nxt_wdata     = m_axi_wdata;
      nxt_wstrb     = m_axi_wstrb;
      nxt_awprot    = m_axi_awprot;
      nxt_arprot    = m_axi_arprot;
      accept        = 1'b0;
      finish        = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_valid && !mem_ready) begin
               accept      = 1'b1;
               nxt_awaddr  = mem_addr;
               nxt_araddr  = mem_addr;
               nxt_wdata   = mem_wdata;
               nxt_wstrb   = mem_wstrb;
               nxt_awprot  = prot_of(mem_instr);
               nxt_arprot  = prot_of(mem_instr);
               nxt_aw_done = 1'b0;
               nxt_w_done  = 1'b0;
               if (mem_wstrb == 4'b0000) begin
                  nxt_arvalid = 1'b1;
                  nxt_state   = S_RD_ADDR;
               end else begin
                  nxt_awvalid = 1'b1;
                  nxt_wvalid  = 1'b1;
                  nxt_state   = S_WR;
               end
            end
         end
         S_RD_ADDR: begin
            if (m_axi_arvalid && m_axi_arready) begin
               nxt_arvalid = 1'b0;
               nxt_rready  = 1'b1;
               nxt_state   = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (m_axi_rvalid && m_axi_rready) begin
               finish        = 1'b1;
               nxt_mem_rdata = m_axi_rdata;
               nxt_rready    = 1'b0;
               nxt_mem_ready = 1'b1;
               nxt_state     = S_DONE;
            end
         end
         S_WR: begin
            nxt_aw_done = aw_done | aw_hs;
            nxt_w_done  = w_done | w_hs;
            if (aw_hs) nxt_awvalid = 1'b0;
            if (w_hs)  nxt_wvalid  = 1'b0;
            if (nxt_aw_done && nxt_w_done) begin
               nxt_bready = 1'b1;
               nxt_state  = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            if (m_axi_bvalid && m_axi_bready) begin
               finish        = 1'b1;
               nxt_bready    = 1'b0;
               nxt_mem_ready = 1'b1;
               nxt_state     = S_DONE;
            end
         end
         S_DONE: begin
            nxt_mem_ready = 1'b0;
            nxt_bus_err   = 1'b0;
            nxt_state     = S_IDLE;
         end
         default: nxt_state = S_IDLE;
      endcase
      if (expire && !finish) begin
         nxt_awvalid   = 1'b0;
         nxt_wvalid    = 1'b0;
         nxt_bready    = 1'b0;
         nxt_arvalid   = 1'b0;
         nxt_rready    = 1'b0;
         nxt_mem_ready = 1'b1;
         nxt_bus_err   = 1'b1;
         nxt_state     = S_DONE;
         if (state == S_RD_ADDR || state == S_RD_DATA) nxt_mem_rdata = ERR_RDATA;
      end
   end

   // State and registered outputs; reset also drops any in-flight request.
   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         state         <= S_IDLE;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_rready  <= 1'b0;
         mem_ready     <= 1'b0;
         bus_err       <= 1'b0;
         mem_rdata     <= '0;
         m_axi_awaddr  <= '0;
         m_axi_araddr  <= '0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_awprot  <= '0;
         m_axi_arprot  <= '0;
      end else begin
         state         <= nxt_state;
         aw_done       <= nxt_aw_done;
         w_done        <= nxt_w_done;
         m_axi_awvalid <= nxt_awvalid;
         m_axi_wvalid  <= nxt_wvalid;
         m_axi_bready  <= nxt_bready;
         m_axi_arvalid <= nxt_arvalid;
         m_axi_rready  <= nxt_rready;
         mem_ready     <= nxt_mem_ready;
         bus_err       <= nxt_bus_err;
         mem_rdata     <= nxt_mem_rdata;
         m_axi_awaddr  <= nxt_awaddr;
         m_axi_araddr  <= nxt_araddr;
         m_axi_wdata   <= nxt_wdata;
         m_axi_wstrb   <= nxt_wstrb;
         m_axi_awprot  <= nxt_awprot;
         m_axi_arprot  <= nxt_arprot;
      end
   end

endmodule

// File: tb/tb_axil_master_bridge.sv
// tb/tb_axil_master_bridge.sv - directed self-checking bench for axil_master_bridge
module tb_axil_master_bridge;
   import axil_pkg::*;

   logic        CLK = 1'b0;
   logic        RSTb;
   logic        mem_valid, mem_instr;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready, bus_err;
   logic [31:0] mem_rdata;
   logic        m_axi_awvalid, m_axi_awready;
   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_wvalid, m_axi_wready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_bvalid, m_axi_bready;
   logic        m_axi_arvalid, m_axi_arready;
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_rvalid, m_axi_rready;
   logic [31:0] m_axi_rdata;

   int n_tests = 0;
   int n_fail  = 0;
   logic early;

   axil_master_bridge #(.TIMEOUT_CYCLES(16), .ERR_RDATA(32'hdeadbeef)) dut (
      .CLK(CLK), .RSTb(RSTb),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .bus_err(bus_err),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_rdata(m_axi_rdata)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      RSTb = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0;
      mem_wdata = '0; mem_wstrb = '0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
      m_axi_bvalid = 1'b0; m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
      tick(); tick();
      check("rst_ctrl", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                            m_axi_rready, mem_ready, bus_err}), 32'h0);
      check("rst_rdata", mem_rdata, 32'h0);
      check("rst_addr_data", m_axi_araddr | m_axi_awaddr | m_axi_wdata, 32'h0);
      check("rst_prot_strb", 32'({m_axi_awprot, m_axi_arprot, m_axi_wstrb}), 32'h0);

      // Read from ROM
      RSTb = 1'b1;
      mem_valid = 1'b1; mem_addr = {REGION_ROM, 28'h000_0010}; mem_wstrb = 4'b0000;
      tick();
      check("rd_arvalid", 32'(m_axi_arvalid), 32'h1);
      check("rd_araddr", m_axi_araddr, 32'h0000_0010);
      check("rd_arprot", 32'(m_axi_arprot), 32'h0);
      check("rd_no_aw", 32'({m_axi_awvalid, m_axi_wvalid}), 32'h0);
      m_axi_arready = 1'b1;
      tick();
      check("rd_ar_hs", 32'({m_axi_arvalid, m_axi_rready, mem_ready}), 32'b010);
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h1234_5678;
      tick();
      check("rd_done", 32'({mem_ready, bus_err, m_axi_rready}), 32'b100);
      check("rd_rdata", mem_rdata, 32'h1234_5678);
      check("rd_araddr_held", m_axi_araddr, 32'h0000_0010);
      mem_valid = 1'b0; m_axi_rvalid = 1'b0;
      tick();
      check("rd_pulse_one", 32'(mem_ready), 32'h0);

      // Instruction fetch, CPU keeps mem_valid high across completion
      mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h0000_0000;
      tick();
      check("if_arprot", 32'(m_axi_arprot), 32'h4);
      m_axi_arready = 1'b1;
      tick();
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0bad_f00d;
      tick();
      check("if_done", 32'({mem_ready, bus_err}), 32'b10);
      check("if_rdata", mem_rdata, 32'h0bad_f00d);
      m_axi_rvalid = 1'b0;
      tick();
      check("if_no_accept_in_done", 32'({m_axi_arvalid, mem_ready}), 32'h0);
      tick();
      check("if_accept_after_done", 32'(m_axi_arvalid), 32'h1);
      mem_valid = 1'b0; mem_instr = 1'b0; m_axi_arready = 1'b1;
      tick();
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h0000_0013;
      tick();
      check("if2_done", 32'(mem_ready), 32'h1);
      m_axi_rvalid = 1'b0;
      tick();

      // Write to RAM, AW handshake three cycles before W
      mem_valid = 1'b1; mem_addr = {REGION_RAM, 28'h000_0004};
      mem_wdata = 32'hcafe_f00d; mem_wstrb = 4'b0011;
      tick();
      check("wr_valids", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 32'b110);
      check("wr_awaddr", m_axi_awaddr, 32'h1000_0004);
      check("wr_wdata", m_axi_wdata, 32'hcafe_f00d);
      check("wr_wstrb", 32'(m_axi_wstrb), 32'h3);
      m_axi_awready = 1'b1;
      tick();
      check("wr_aw_first", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'b010);
      m_axi_awready = 1'b0;
      tick(); tick();
      check("wr_w_holds", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'b010);
      m_axi_wready = 1'b1;
      tick();
      check("wr_both_done", 32'({m_axi_wvalid, m_axi_bready, mem_ready}), 32'b010);
      check("wr_wdata_held", m_axi_wdata, 32'hcafe_f00d);
      m_axi_wready = 1'b0; m_axi_bvalid = 1'b1;
      tick();
      check("wr_resp", 32'({mem_ready, bus_err, m_axi_bready}), 32'b100);
      mem_valid = 1'b0; m_axi_bvalid = 1'b0;
      tick();
      check("wr_pulse_one", 32'(mem_ready), 32'h0);

      // UART write with simultaneous AW/W handshake
      mem_valid = 1'b1; mem_addr = {REGION_UART, 28'h000_0000};
      mem_wdata = 32'h0000_0041; mem_wstrb = 4'b0001;
      tick();
      m_axi_awready = 1'b1; m_axi_wready = 1'b1;
      tick();
      check("uart_one_step", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 32'b001);
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b1;
      tick();
      check("uart_resp", 32'(mem_ready), 32'h1);
      check("uart_data_held", {m_axi_wdata[27:0], m_axi_wstrb}, 32'h0000_0411);
      check("uart_awaddr", m_axi_awaddr, 32'h2000_0000);
      mem_valid = 1'b0; m_axi_bvalid = 1'b0;
      tick();

      // Read timeout: slave never raises arready
      mem_valid = 1'b1; mem_addr = 32'h0000_0020; mem_wstrb = 4'b0000;
      tick();
      early = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         tick();
         early = early | mem_ready;
      end
      check("to_not_early", 32'({early, m_axi_arvalid}), 32'b01);
      tick();
      check("to_abort", 32'({mem_ready, bus_err}), 32'b11);
      check("to_rdata", mem_rdata, 32'hdeadbeef);
      check("to_valids_clear", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                   m_axi_arvalid, m_axi_rready}), 32'h0);
      mem_valid = 1'b0; m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h5555_5555;
      tick();
      early = 1'b0;
      check("to_pulse_one", 32'({mem_ready, bus_err}), 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         early = early | mem_ready | bus_err | m_axi_rready;
      end
      check("to_late_ignored", 32'(early), 32'h0);
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;

      // Reset during WR_RESP, then a normal read
      mem_valid = 1'b1; mem_addr = 32'h1000_0008; mem_wdata = 32'h1122_3344; mem_wstrb = 4'b1111;
      tick();
      m_axi_awready = 1'b1; m_axi_wready = 1'b1;
      tick();
      check("rstw_in_resp", 32'(m_axi_bready), 32'h1);
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; mem_valid = 1'b0; RSTb = 1'b0;
      tick();
      check("rstw_ctrl", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                             m_axi_rready, mem_ready, bus_err}), 32'h0);
      check("rstw_data", m_axi_awaddr | m_axi_wdata | 32'(m_axi_wstrb), 32'h0);
      RSTb = 1'b1;
      mem_valid = 1'b1; mem_addr = 32'h0000_0100; mem_wstrb = 4'b0000;
      tick();
      check("rstw_rd_ar", m_axi_araddr, 32'h0000_0100);
      m_axi_arready = 1'b1;
      tick();
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 32'ha5a5_5a5a;
      tick();
      check("rstw_rd_done", 32'({mem_ready, bus_err}), 32'b10);
      check("rstw_rd_data", mem_rdata, 32'ha5a5_5a5a);
      mem_valid = 1'b0; m_axi_rvalid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
